// File: rtl/hdmi_rst_pkg.sv
// Shared types and constants for the HDMI reset-release sequencer.
package hdmi_rst_pkg;

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StStable   = 3'd1,
        StRelease  = 3'd2,
        StRun      = 3'd3,
        StHold     = 3'd4
    } state_e;

    localparam int unsigned LOCK_LOST_CNT_W = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high clear.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/hdmi_rst_seq.sv
// Reset-release sequencer: waits for stable PLL lock, then releases stage resets in order.
module hdmi_rst_seq
    import hdmi_rst_pkg::*;
#(
    parameter int unsigned NUM_STAGES         = 3,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_GAP_CYCLES   = 16,
    parameter int unsigned HOLD_CYCLES        = 64
) (
    input  logic                       clk_i,
    input  logic                       syn_reset_i,
    input  logic                       pll_locked_i,
    input  logic                       soft_rst_req_i,
    output logic [NUM_STAGES-1:0]      stage_rst_o,
    output logic                       ready_o,
    output logic [LOCK_LOST_CNT_W-1:0] lock_lost_cnt_o,
    output logic [2:0]                 state_o
);

    localparam int unsigned CntMax = max3(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES, HOLD_CYCLES);
    localparam int unsigned CntW   = $clog2(CntMax) + 1;
    localparam int unsigned IdxW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CntW-1:0] StableLast = CntW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast    = CntW'(STAGE_GAP_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast    = IdxW'(NUM_STAGES - 1);

    logic lock_s;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic [NUM_STAGES-1:0]      stage_rst_q, stage_rst_d;
    logic                       ready_q, ready_d;
    logic [LOCK_LOST_CNT_W-1:0] llc_q, llc_d;

    sync_2ff u_lock_sync (
        .clk_i (clk_i),
        .rst_i (syn_reset_i),
        .d_i   (pll_locked_i),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst_q;
        ready_d     = ready_q;
        llc_d       = llc_q;

        unique case (state_q)
            StWaitLock: begin
                stage_rst_d = '1;
                ready_d     = 1'b0;
                if (soft_rst_req_i) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (lock_s) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end
            end
            StStable: begin
                if (soft_rst_req_i) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d     = StRelease;
                    cnt_d       = '0;
                    idx_d       = '0;
                    // Left shift keeps the released stages a contiguous low-order run.
                    stage_rst_d = stage_rst_q << 1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease, StRun: begin
                if (!lock_s || soft_rst_req_i) begin
                    state_d     = StHold;
                    cnt_d       = '0;
                    idx_d       = '0;
                    stage_rst_d = '1;
                    ready_d     = 1'b0;
                    if (!lock_s && (llc_q != '1)) begin
                        llc_d = llc_q + 1'b1;
                    end
                end else if (state_q == StRelease) begin
                    if (cnt_q == GapLast) begin
                        cnt_d = '0;
                        if (idx_q == IdxLast) begin
                            state_d = StRun;
                            ready_d = 1'b1;
                        end else begin
                            idx_d       = idx_q + 1'b1;
                            stage_rst_d = stage_rst_q << 1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StHold: begin
                stage_rst_d = '1;
                ready_d     = 1'b0;
                if (cnt_q == HoldLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = StWaitLock;
                cnt_d       = '0;
                stage_rst_d = '1;
                ready_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (syn_reset_i) begin
            state_q     <= StWaitLock;
            cnt_q       <= '0;
            idx_q       <= '0;
            stage_rst_q <= '1;
            ready_q     <= 1'b0;
            llc_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
            ready_q     <= ready_d;
            llc_q       <= llc_d;
        end
    end

    assign stage_rst_o     = stage_rst_q;
    assign ready_o         = ready_q;
    assign lock_lost_cnt_o = llc_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_hdmi_rst_seq.sv
// Self-checking bench for hdmi_rst_seq against a phase/elapsed-time reference model.
module tb_hdmi_rst_seq;

    localparam int unsigned NS   = 3;
    localparam int unsigned LS   = 8;
    localparam int unsigned GAP  = 4;
    localparam int unsigned HOLD = 5;

    logic          clk = 1'b0;
    logic          syn_reset;
    logic          pll_locked;
    logic          soft_rst_req;
    logic [NS-1:0] stage_rst;
    logic          ready;
    logic [7:0]    lock_lost_cnt;
    logic [2:0]    state;

    int checks   = 0;
    int failures = 0;

    // Model: mode 0 wait, 1 stable, 2 release, 3 run, 4 hold; t = cycles elapsed in mode.
    int m_mode = 0;
    int m_t    = 0;
    int m_llc  = 0;
    bit m_s1   = 1'b0;
    bit m_s2   = 1'b0;

    always #5 clk = ~clk;

    hdmi_rst_seq #(
        .NUM_STAGES         (NS),
        .LOCK_STABLE_CYCLES (LS),
        .STAGE_GAP_CYCLES   (GAP),
        .HOLD_CYCLES        (HOLD)
    ) dut (
        .clk_i           (clk),
        .syn_reset_i     (syn_reset),
        .pll_locked_i    (pll_locked),
        .soft_rst_req_i  (soft_rst_req),
        .stage_rst_o     (stage_rst),
        .ready_o         (ready),
        .lock_lost_cnt_o (lock_lost_cnt),
        .state_o         (state)
    );

    wire [NS+11:0] dut_vec = {stage_rst, ready, state, lock_lost_cnt};

    // Stage k is released once k gaps have elapsed in the release phase.
    function automatic logic [NS+11:0] exp_vec();
        logic [NS-1:0] r;
        for (int k = 0; k < NS; k++) begin
            r[k] = !((m_mode == 3) || (m_mode == 2 && m_t >= k * GAP));
        end
        return {r, 1'(m_mode == 3), 3'(m_mode), 8'(m_llc)};
    endfunction

    task automatic enter_hold(input bit lost);
        if (lost && m_llc < 255) m_llc++;
        m_mode = 4;
        m_t    = 0;
    endtask

    task automatic model_step();
        bit ls;
        if (syn_reset) begin
            m_mode = 0; m_t = 0; m_llc = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = pll_locked;
            case (m_mode)
                0: if (soft_rst_req) enter_hold(0);
                   else if (ls) begin m_mode = 1; m_t = 0; end
                1: if (soft_rst_req) enter_hold(0);
                   else if (!ls) begin m_mode = 0; m_t = 0; end
                   else if (m_t == LS - 1) begin m_mode = 2; m_t = 0; end
                   else m_t++;
                2, 3: if (!ls || soft_rst_req) enter_hold(!ls);
                   else if (m_mode == 2) begin
                       m_t++;
                       if (m_t == NS * GAP) begin m_mode = 3; m_t = 0; end
                   end
                default: if (m_t == HOLD - 1) begin m_mode = 0; m_t = 0; end
                   else m_t++;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        syn_reset = 1'b1;
        tick();
        syn_reset = 1'b0;
    endtask

    task automatic test_reset();
        syn_reset = 1'b1; pll_locked = 1'b0; soft_rst_req = 1'b0;
        tick(); tick();
        checks++;
        if (stage_rst !== 3'b111 || ready !== 1'b0 || state !== 3'd0 || lock_lost_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_values: got rst=%b rdy=%b st=%0d llc=%0d want 111 0 0 0",
                     stage_rst, ready, state, lock_lost_cnt);
        end
        syn_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_clean_bringup();
        do_reset();
        pll_locked = 1'b1;
        for (int e = 0; e <= 24; e++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL bringup_model e=%0d: got %h want %h", e, dut_vec, exp_vec());
            end
            if (e == 9 || e == 10 || e == 14 || e == 18) begin
                checks++;
                if (stage_rst !== ((e == 9) ? 3'b111 : (e == 10) ? 3'b110 :
                                   (e == 14) ? 3'b100 : 3'b000)) begin
                    failures++;
                    $display("FAIL bringup_stage e=%0d: got %b", e, stage_rst);
                end
            end
            if (e == 21 || e == 22) begin
                checks++;
                if (ready !== (e == 22) || lock_lost_cnt !== 8'd0) begin
                    failures++;
                    $display("FAIL bringup_ready e=%0d: got rdy=%b llc=%0d", e, ready, lock_lost_cnt);
                end
            end
        end
    endtask

    task automatic test_lock_glitch();
        do_reset();
        pll_locked = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            pll_locked = (e != 7);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL glitch_model e=%0d: got %h want %h", e, dut_vec, exp_vec());
            end
            if (e == 9 || e == 17 || e == 18) begin
                checks++;
                if ((e == 9 && state !== 3'd0) || (e == 17 && stage_rst !== 3'b111) ||
                    (e == 18 && stage_rst !== 3'b110) || lock_lost_cnt !== 8'd0) begin
                    failures++;
                    $display("FAIL glitch_restart e=%0d: got st=%0d rst=%b llc=%0d",
                             e, state, stage_rst, lock_lost_cnt);
                end
            end
        end
    endtask

    task automatic test_lock_loss_run();
        do_reset();
        pll_locked = 1'b1;
        for (int e = 0; e < 24; e++) tick();
        pll_locked = 1'b0;
        for (int f = 0; f <= 8; f++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL loss_model f=%0d: got %h want %h", f, dut_vec, exp_vec());
            end
            if (f == 1 || f == 2 || f == 6 || f == 7) begin
                checks++;
                if ((f == 1 && ready !== 1'b1) ||
                    (f == 2 && (stage_rst !== 3'b111 || ready !== 1'b0 || lock_lost_cnt !== 8'd1)) ||
                    (f == 6 && state !== 3'd4) || (f == 7 && state !== 3'd0)) begin
                    failures++;
                    $display("FAIL loss_timing f=%0d: got rst=%b rdy=%b st=%0d llc=%0d",
                             f, stage_rst, ready, state, lock_lost_cnt);
                end
            end
        end
        pll_locked = 1'b1;
        for (int e = 0; e < 25; e++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL loss_rebringup e=%0d: got %h want %h", e, dut_vec, exp_vec());
            end
        end
        checks++;
        if (ready !== 1'b1 || lock_lost_cnt !== 8'd1) begin
            failures++;
            $display("FAIL loss_ready_again: got rdy=%b llc=%0d want 1 1", ready, lock_lost_cnt);
        end
    endtask

    task automatic test_soft_in_release();
        logic [7:0] llc0;
        do_reset();
        pll_locked = 1'b1;
        for (int e = 0; e <= 11; e++) tick();
        llc0 = 8'(m_llc);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        checks++;
        if (stage_rst !== 3'b111 || state !== 3'd4) begin
            failures++;
            $display("FAIL soft_one_edge: got rst=%b st=%0d want 111 4", stage_rst, state);
        end
        for (int s = 1; s <= 8; s++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec() || state !== ((s <= 4) ? 3'd4 : (s == 5) ? 3'd0 : 3'd1)) begin
                failures++;
                $display("FAIL soft_hold s=%0d: got %h want %h", s, dut_vec, exp_vec());
            end
        end
        checks++;
        if (lock_lost_cnt !== llc0) begin
            failures++;
            $display("FAIL soft_llc: got %0d want %0d", lock_lost_cnt, llc0);
        end
    endtask

    task automatic test_simultaneous_and_saturation();
        int guard;
        do_reset();
        pll_locked = 1'b1;
        for (int e = 0; e < 24; e++) tick();
        pll_locked = 1'b0;
        tick(); tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        checks++;
        if (lock_lost_cnt !== 8'd1 || state !== 3'd4 || stage_rst !== 3'b111) begin
            failures++;
            $display("FAIL simultaneous: got llc=%0d st=%0d rst=%b want 1 4 111",
                     lock_lost_cnt, state, stage_rst);
        end
        for (int n = 0; n < 300; n++) begin
            pll_locked = 1'b1;
            guard = 0;
            while (m_mode != 2 && guard < 40) begin tick(); guard++; end
            pll_locked = 1'b0;
            while (m_mode != 4 && guard < 50) begin tick(); guard++; end
            checks++;
            if (guard >= 50 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL saturate_iter n=%0d guard=%0d: got %h want %h",
                         n, guard, dut_vec, exp_vec());
            end
        end
        checks++;
        if (lock_lost_cnt !== 8'd255) begin
            failures++;
            $display("FAIL saturate_cap: got %0d want 255", lock_lost_cnt);
        end
    endtask

    task automatic test_reset_mid_release();
        int guard = 0;
        pll_locked = 1'b1;
        while (m_mode != 2 && guard < 40) begin tick(); guard++; end
        tick(); tick();
        checks++;
        if (guard >= 40 || state !== 3'd2) begin
            failures++;
            $display("FAIL midrel_reach: got st=%0d want 2", state);
        end
        syn_reset = 1'b1;
        tick();
        syn_reset = 1'b0;
        checks++;
        if (stage_rst !== 3'b111 || ready !== 1'b0 || state !== 3'd0 || lock_lost_cnt !== 8'd0) begin
            failures++;
            $display("FAIL midrel_reset: got rst=%b rdy=%b st=%0d llc=%0d want 111 0 0 0",
                     stage_rst, ready, state, lock_lost_cnt);
        end
        for (int e = 0; e <= 22; e++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec() || (e == 10 && stage_rst !== 3'b110) ||
                (e == 22 && ready !== 1'b1)) begin
                failures++;
                $display("FAIL midrel_restart e=%0d: got %h want %h", e, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (pll_locked) pll_locked = ($urandom_range(39) != 0);
            else            pll_locked = ($urandom_range(7) == 0);
            soft_rst_req = ($urandom_range(59) == 0);
            syn_reset    = ($urandom_range(499) == 0);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random i=%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        syn_reset = 1'b0; soft_rst_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_bringup();
        test_lock_glitch();
        test_lock_loss_run();
        test_soft_in_release();
        test_simultaneous_and_saturation();
        test_reset_mid_release();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
